mod_counter_run_sequencer: RTL and testbench
============================================

Name: mod_counter_run_sequencer

Overview:
Command sequencer that sits directly upstream of the 4-bit MOD counter and drives its Load/Start/Stop command inputs. On one run request it loads a preload value, starts the counter, and counts the counter's rollover pulses. It stops the counter after a programmed number of rollovers, or on abort, and then reports Done. It also watches the counter's running flag and flags a handshake failure if the counter does not respond within a fixed number of cycles.

Parameters:
COUNT_WIDTH, 4, width of the preload and MOD values passed to the counter
ROLL_WIDTH, 8, width of the rollover target and the rollover count
ACK_TIMEOUT, 4, cycles to wait for the running flag to change before Error_Out

Ports:
Clk_In  in  1  clock; all logic on posedge
tb_Reset_In  in  1  reset, asynchronous, active-high
Enable_In  in  1  1 = sequencer advances; 0 = freeze
Run_Request_In  in  1  single-cycle pulse that starts a run
Abort_Request_In  in  1  single-cycle pulse that ends the current run early
Preload_Value_In  in  COUNT_WIDTH  preload value, captured on an accepted run
MOD_Value_In  in  COUNT_WIDTH  modulus, captured on an accepted run
Rollover_Target_In  in  ROLL_WIDTH  number of rollovers per run, captured on an accepted run
Counter_Running_Flag_In  in  1  running flag from the counter
Counter_Rollover_Flag_In  in  1  rollover flag from the counter; high for 1 cycle per wrap
Load_Counter_Value_Command_Out  out  1  load command to the counter
Start_Counter_Command_Out  out  1  start command to the counter
Stop_Counter_Command_Out  out  1  stop command to the counter
Preload_Counter_Value_Out  out  COUNT_WIDTH  captured preload value
MOD_Value_Out  out  COUNT_WIDTH  captured modulus
Rollover_Count_Out  out  ROLL_WIDTH  rollovers counted in the current or last run
Busy_Out  out  1  high whenever state is not IDLE
Done_Out  out  1  1-cycle pulse when a run completes
Aborted_Out  out  1  valid with Done_Out; 1 = run ended by abort
Error_Out  out  1  1-cycle pulse on a rejected request or a handshake timeout

Behaviour:
- Reset (async, tb_Reset_In=1): state goes to IDLE and every output and internal register goes to 0.
- All outputs are registered.
- Each command output is high for exactly 1 cycle per visit to its state.
- States and transitions:
  - IDLE: when Run_Request_In=1 and Enable_In=1:
    - capture Preload, MOD and Target;
    - if MOD_Value_In<2 or Rollover_Target_In=0, pulse Error_Out next cycle and stay in IDLE;
    - otherwise clear Rollover_Count_Out and go to LOAD.
  - LOAD: Load command=1 for one cycle, then go to START.
  - START: Start command=1 for one cycle, then go to WAIT_RUN and clear the timeout counter.
  - WAIT_RUN: go to RUNNING when Counter_Running_Flag_In=1. After ACK_TIMEOUT cycles without it, pulse Error_Out and return to IDLE (no Done).
  - RUNNING: each cycle with Counter_Rollover_Flag_In=1 increments Rollover_Count_Out.
    - When the incremented value equals Target, go to STOP with aborted=0.
    - On Abort_Request_In=1, go to STOP with aborted=1.
    - If both happen in the same cycle, the target wins: the count increments and aborted=0.
  - STOP: Stop command=1 for one cycle, then go to WAIT_STOP.
  - WAIT_STOP: go to DONE when Counter_Running_Flag_In=0. On timeout, pulse Error_Out and go to IDLE.
  - DONE: Done_Out=1 and Aborted_Out=aborted for one cycle, then go to IDLE.
- Rollover_Count_Out holds its value after Done until the next accepted run.
- An Abort in any state other than RUNNING is ignored.
- Run_Request_In while Busy_Out=1 is ignored.
- Enable_In=0:
  - state, timeout and rollover counter freeze;
  - all command outputs are forced to 0;
  - a command state re-issues its 1-cycle pulse once Enable returns;
  - Rollover flags and Abort pulses seen while disabled are ignored.
- Preload_Counter_Value_Out and MOD_Value_Out always show the captured values, so the downstream counter sees stable inputs during LOAD.
- Preload values >= MOD are passed through unclipped; the counter clamps them.
- Rollover_Count_Out saturates at all-ones and never wraps.

Test Plan:
- Reset mid-RUNNING (count=3) -> in the same cycle every output is 0, Busy=0, state is IDLE.
- Run with Preload=5, MOD=10, Target=2, counter model responding 1 cycle later -> Load, Start, Stop each pulse once in that order; Done=1 with Aborted=0; Rollover_Count_Out=2; Busy falls the cycle after Done.
- Run with MOD=1, Target=3 -> Error_Out pulses once and Busy stays 0. Run with MOD=10, Target=0 -> same result.
- Running flag never asserted -> Error_Out 4 cycles after WAIT_RUN is entered, no Done, state returns to IDLE.
- Abort after 1 rollover with Target=5 -> Stop pulse, then Done=1 with Aborted=1 and Rollover_Count_Out=1. Abort in the same cycle as the 5th rollover -> Aborted=0, count=5.
- Enable_In=0 for 3 cycles while in START -> no Start pulse while disabled; exactly one Start pulse after re-enable. A second Run_Request during RUNNING is ignored.

Source files
------------

// File: rtl/mod_counter_run_sequencer.sv
// Run sequencer for the 4-bit MOD counter: issues Load/Start/Stop, counts rollovers,
// and reports Done/Aborted, or Error on a rejected request or a handshake timeout.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for a run request
// LOAD       | issue the load command
// START      | issue the start command and arm the handshake timer
// WAIT_RUN   | wait for the counter's running flag to rise
// RUNNING    | count rollovers until the target is reached or an abort arrives
// STOP       | issue the stop command and arm the handshake timer
// WAIT_STOP  | wait for the counter's running flag to fall
// DONE       | report completion
module mod_counter_run_sequencer #(
  parameter int COUNT_WIDTH = 4,
  parameter int ROLL_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                   Clk_In,
  input  logic                   tb_Reset_In,
  input  logic                   Enable_In,
  input  logic                   Run_Request_In,
  input  logic                   Abort_Request_In,
  input  logic [COUNT_WIDTH-1:0] Preload_Value_In,
  input  logic [COUNT_WIDTH-1:0] MOD_Value_In,
  input  logic [ROLL_WIDTH-1:0]  Rollover_Target_In,
  input  logic                   Counter_Running_Flag_In,
  input  logic                   Counter_Rollover_Flag_In,
  output logic                   Load_Counter_Value_Command_Out,
  output logic                   Start_Counter_Command_Out,
  output logic                   Stop_Counter_Command_Out,
  output logic [COUNT_WIDTH-1:0] Preload_Counter_Value_Out,
  output logic [COUNT_WIDTH-1:0] MOD_Value_Out,
  output logic [ROLL_WIDTH-1:0]  Rollover_Count_Out,
  output logic                   Busy_Out,
  output logic                   Done_Out,
  output logic                   Aborted_Out,
  output logic                   Error_Out
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_RUN, S_RUNNING, S_STOP, S_WAIT_STOP, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [ROLL_WIDTH-1:0]  count_q, count_d, count_inc;
  logic [ROLL_WIDTH-1:0]  target_q, target_d;
  logic [COUNT_WIDTH-1:0] preload_q, preload_d;
  logic [COUNT_WIDTH-1:0] mod_q, mod_d;
  logic                   aborted_q, aborted_d;
  logic                   load_q, load_d;
  logic                   start_q, start_d;
  logic                   stop_q, stop_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   abo_q, abo_d;
  logic                   err_q, err_d;

  assign count_inc = (count_q == '1) ? count_q : count_q + ROLL_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    count_d   = count_q;
    target_d  = target_q;
    preload_d = preload_q;
    mod_d     = mod_q;
    aborted_d = aborted_q;
    load_d    = 1'b0;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    done_d    = 1'b0;
    abo_d     = 1'b0;
    err_d     = 1'b0;
    busy_d    = (state_q != S_IDLE);

    // Outputs are the registered image of the state just processed, so every
    // command pulse lands one cycle after its state and only when enabled.
    if (Enable_In) begin
      case (state_q)
        S_IDLE: begin
          if (Run_Request_In) begin
            preload_d = Preload_Value_In;
            mod_d     = MOD_Value_In;
            target_d  = Rollover_Target_In;
            if ((MOD_Value_In < COUNT_WIDTH'(2)) || (Rollover_Target_In == '0)) begin
              err_d = 1'b1;
            end else begin
              count_d = '0;
              state_d = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          load_d  = 1'b1;
          state_d = S_START;
        end
        S_START: begin
          start_d = 1'b1;
          timer_d = TW'(ACK_TIMEOUT);
          state_d = S_WAIT_RUN;
        end
        S_WAIT_RUN: begin
          if (Counter_Running_Flag_In) begin
            state_d = S_RUNNING;
          end else if (timer_q <= TW'(1)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_RUNNING: begin
          if (Counter_Rollover_Flag_In) count_d = count_inc;
          // Reaching the target takes priority over a simultaneous abort.
          if (Counter_Rollover_Flag_In && (count_inc == target_q)) begin
            aborted_d = 1'b0;
            state_d   = S_STOP;
          end else if (Abort_Request_In) begin
            aborted_d = 1'b1;
            state_d   = S_STOP;
          end
        end
        S_STOP: begin
          stop_d  = 1'b1;
          timer_d = TW'(ACK_TIMEOUT);
          state_d = S_WAIT_STOP;
        end
        S_WAIT_STOP: begin
          if (!Counter_Running_Flag_In) begin
            state_d = S_DONE;
          end else if (timer_q <= TW'(1)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          abo_d   = aborted_q;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_In or posedge tb_Reset_In) begin
    if (tb_Reset_In) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      count_q   <= '0;
      target_q  <= '0;
      preload_q <= '0;
      mod_q     <= '0;
      aborted_q <= 1'b0;
      load_q    <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abo_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      target_q  <= target_d;
      preload_q <= preload_d;
      mod_q     <= mod_d;
      aborted_q <= aborted_d;
      load_q    <= load_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abo_q     <= abo_d;
      err_q     <= err_d;
    end
  end

  assign Load_Counter_Value_Command_Out = load_q;
  assign Start_Counter_Command_Out      = start_q;
  assign Stop_Counter_Command_Out       = stop_q;
  assign Preload_Counter_Value_Out      = preload_q;
  assign MOD_Value_Out                  = mod_q;
  assign Rollover_Count_Out             = count_q;
  assign Busy_Out                       = busy_q;
  assign Done_Out                       = done_q;
  assign Aborted_Out                    = abo_q;
  assign Error_Out                      = err_q;

endmodule

// File: tb/tb_mod_counter_run_sequencer.sv
// Scoreboard bench for mod_counter_run_sequencer: expected command/done/error events
// are queued by the stimulus and consumed by a monitor as the DUT emits them.
module tb_mod_counter_run_sequencer;

  localparam int CW = 4;
  localparam int RW = 8;

  localparam logic [3:0] EV_LOAD  = 4'd1;
  localparam logic [3:0] EV_START = 4'd2;
  localparam logic [3:0] EV_STOP  = 4'd3;
  localparam logic [3:0] EV_DONE  = 4'd4;
  localparam logic [3:0] EV_ERR   = 4'd5;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable, run_req, abort_req;
  logic [CW-1:0] preload_in, mod_in;
  logic [RW-1:0] target_in;
  logic          run_flag, roll_flag;
  logic          load_cmd, start_cmd, stop_cmd;
  logic [CW-1:0] preload_out, mod_out;
  logic [RW-1:0] roll_count;
  logic          busy, done, aborted, error;

  logic          respond;
  int            total = 0;
  int            bad = 0;
  int            start_cnt = 0;
  logic [12:0]   exp_q[$];

  mod_counter_run_sequencer #(.COUNT_WIDTH(CW), .ROLL_WIDTH(RW), .ACK_TIMEOUT(4)) dut (
    .Clk_In                        (clk),
    .tb_Reset_In                   (rst),
    .Enable_In                     (enable),
    .Run_Request_In                (run_req),
    .Abort_Request_In              (abort_req),
    .Preload_Value_In              (preload_in),
    .MOD_Value_In                  (mod_in),
    .Rollover_Target_In            (target_in),
    .Counter_Running_Flag_In       (run_flag),
    .Counter_Rollover_Flag_In      (roll_flag),
    .Load_Counter_Value_Command_Out(load_cmd),
    .Start_Counter_Command_Out     (start_cmd),
    .Stop_Counter_Command_Out      (stop_cmd),
    .Preload_Counter_Value_Out     (preload_out),
    .MOD_Value_Out                 (mod_out),
    .Rollover_Count_Out            (roll_count),
    .Busy_Out                      (busy),
    .Done_Out                      (done),
    .Aborted_Out                   (aborted),
    .Error_Out                     (error)
  );

  always #5 clk = ~clk;

  // Counter stand-in: running flag follows Start/Stop one cycle later.
  always @(posedge clk or posedge rst) begin
    if (rst) run_flag <= 1'b0;
    else if (respond) begin
      if (start_cmd)     run_flag <= 1'b1;
      else if (stop_cmd) run_flag <= 1'b0;
    end
  end

  function automatic logic [12:0] ev(input logic [3:0] kind, input logic ab, input logic [RW-1:0] cnt);
    return {kind, ab, cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [12:0] act;
    logic [12:0] exp;
    logic        hit;
    if (!rst) begin
      hit = 1'b1;
      if (load_cmd)       act = ev(EV_LOAD, 1'b0, '0);
      else if (start_cmd) act = ev(EV_START, 1'b0, '0);
      else if (stop_cmd)  act = ev(EV_STOP, 1'b0, '0);
      else if (done)      act = ev(EV_DONE, aborted, roll_count);
      else if (error)     act = ev(EV_ERR, 1'b0, '0);
      else begin
        hit = 1'b0;
        act = '0;
      end
      if (start_cmd) start_cnt++;
      if (hit) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got %0h expected none", act);
        end else begin
          exp = exp_q.pop_front();
          check("event", 32'(act), 32'(exp));
        end
      end
    end
  end

  task automatic do_run(input logic [CW-1:0] pre, input logic [CW-1:0] m, input logic [RW-1:0] tgt);
    @(posedge clk); #1;
    preload_in = pre; mod_in = m; target_in = tgt; run_req = 1'b1;
    @(posedge clk); #1;
    run_req = 1'b0;
  endtask

  task automatic pulse_roll(input logic with_abort);
    @(posedge clk); #1;
    roll_flag = 1'b1; abort_req = with_abort;
    @(posedge clk); #1;
    roll_flag = 1'b0; abort_req = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1;
    abort_req = 1'b1;
    @(posedge clk); #1;
    abort_req = 1'b0;
  endtask

  task automatic wait_running();
    int n = 0;
    @(negedge clk);
    while (!run_flag && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!run_flag) check("running_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic busy_seen;
    rst = 1'b1; enable = 1'b1; run_req = 1'b0; abort_req = 1'b0; roll_flag = 1'b0;
    preload_in = '0; mod_in = '0; target_in = '0; respond = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", {load_cmd, start_cmd, stop_cmd, preload_out, mod_out, roll_count,
                         busy, done, aborted, error}, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Reset while RUNNING with three rollovers counted.
    exp_q.push_back(ev(EV_LOAD, 0, 0));
    exp_q.push_back(ev(EV_START, 0, 0));
    do_run(4'd5, 4'd10, 8'd5);
    wait_running();
    repeat (3) pulse_roll(1'b0);
    @(negedge clk);
    check("mid_run_count", roll_count, 3);
    check("mid_run_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outs", {load_cmd, start_cmd, stop_cmd, preload_out, mod_out, roll_count,
                               busy, done, aborted, error}, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Normal run, target 2.
    exp_q.push_back(ev(EV_LOAD, 0, 0));
    exp_q.push_back(ev(EV_START, 0, 0));
    exp_q.push_back(ev(EV_STOP, 0, 0));
    exp_q.push_back(ev(EV_DONE, 0, 2));
    do_run(4'd5, 4'd10, 8'd2);
    wait_running();
    check("preload_out", preload_out, 5);
    check("mod_out", mod_out, 10);
    pulse_roll(1'b0);
    pulse_roll(1'b0);
    wait_done();
    check("busy_at_done", busy, 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("count_held", roll_count, 2);

    // Rejected requests: MOD below 2, then zero target.
    exp_q.push_back(ev(EV_ERR, 0, 0));
    do_run(4'd0, 4'd1, 8'd3);
    @(negedge clk);
    check("reject_mod_err", error, 1);
    busy_seen = 1'b0;
    repeat (3) begin @(negedge clk); busy_seen = busy_seen | busy | error; end
    check("reject_mod_quiet", busy_seen, 0);
    exp_q.push_back(ev(EV_ERR, 0, 0));
    do_run(4'd0, 4'd10, 8'd0);
    @(negedge clk);
    check("reject_tgt_err", error, 1);
    busy_seen = 1'b0;
    repeat (3) begin @(negedge clk); busy_seen = busy_seen | busy | error; end
    check("reject_tgt_quiet", busy_seen, 0);

    // Counter never answers: Error four cycles after the Start pulse.
    respond = 1'b0;
    exp_q.push_back(ev(EV_LOAD, 0, 0));
    exp_q.push_back(ev(EV_START, 0, 0));
    exp_q.push_back(ev(EV_ERR, 0, 0));
    do_run(4'd2, 4'd10, 8'd3);
    n = 0;
    while (!start_cmd && n < 20) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!error && n < 20);
    check("timeout_delay", n, 4);
    @(negedge clk);
    check("timeout_idle", busy, 0);
    respond = 1'b1;
    repeat (3) @(negedge clk);

    // Abort after one rollover; an abort before RUNNING is ignored.
    exp_q.push_back(ev(EV_LOAD, 0, 0));
    exp_q.push_back(ev(EV_START, 0, 0));
    exp_q.push_back(ev(EV_STOP, 0, 0));
    exp_q.push_back(ev(EV_DONE, 1, 1));
    do_run(4'd0, 4'd10, 8'd5);
    pulse_abort();
    wait_running();
    pulse_roll(1'b0);
    pulse_abort();
    wait_done();

    // Abort coinciding with the final rollover: target wins.
    exp_q.push_back(ev(EV_LOAD, 0, 0));
    exp_q.push_back(ev(EV_START, 0, 0));
    exp_q.push_back(ev(EV_STOP, 0, 0));
    exp_q.push_back(ev(EV_DONE, 0, 5));
    do_run(4'd3, 4'd10, 8'd5);
    wait_running();
    repeat (4) pulse_roll(1'b0);
    pulse_roll(1'b1);
    wait_done();

    // Disable while in START, second run ignored, inputs ignored while disabled.
    exp_q.push_back(ev(EV_LOAD, 0, 0));
    exp_q.push_back(ev(EV_START, 0, 0));
    exp_q.push_back(ev(EV_STOP, 0, 0));
    exp_q.push_back(ev(EV_DONE, 0, 2));
    n = start_cnt;
    @(posedge clk); #1;
    preload_in = 4'd3; mod_in = 4'd10; target_in = 8'd2; run_req = 1'b1;
    @(posedge clk); #1;
    run_req = 1'b0;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("no_start_disabled", start_cnt - n, 0);
    @(posedge clk); #1;
    enable = 1'b1;
    wait_running();
    check("one_start_reenabled", start_cnt - n, 1);
    do_run(4'd7, 4'd1, 8'd9);
    @(negedge clk);
    check("second_run_mod", mod_out, 10);
    check("second_run_pre", preload_out, 3);
    @(posedge clk); #1;
    enable = 1'b0; roll_flag = 1'b1; abort_req = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1; roll_flag = 1'b0; abort_req = 1'b0;
    @(negedge clk);
    check("disabled_roll_ignored", roll_count, 0);
    pulse_roll(1'b0);
    pulse_roll(1'b0);
    wait_done();

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
